// File: rtl/alu_if.sv
// ALU operand/result bundle between the BIST sequencer and the 16-bit ALU.
interface alu_if #(
    parameter int WIDTH = 16
);
    logic [2:0]       ALUop;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [WIDTH-1:0] ALUresult;
    logic             flagN;
    logic             flagZ;

    modport master (
        output ALUop, srcA, srcB,
        input  ALUresult, flagN, flagZ
    );

    modport slave (
        input  ALUop, srcA, srcB,
        output ALUresult, flagN, flagZ
    );
endinterface

// File: rtl/alu_bist.sv
// ALU built-in self-test: replays a golden vector table through the ALU
// and tallies result/flag mismatches for bring-up status reporting.
module alu_bist #(
    parameter int WIDTH   = 16,
    parameter int NUM_VEC = 7,
    parameter int SETTLE  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    alu_if.master      bus,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count,
    output logic [2:0] fail_idx,
    output logic [2:0] vec_idx
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_DONE
    } state_t;

    state_t           r_state, w_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_busy, r_done, r_pass;
    logic [2:0]       r_fc, r_fi, r_vi;
    logic [1:0]       r_wait;

    logic [2:0]       w_g_op;
    logic [WIDTH-1:0] w_g_a, w_g_b, w_g_res;
    logic             w_g_n, w_g_z;
    logic             w_last, w_wait_end, w_mis, w_go;
    logic [2:0]       w_fc_nx;

    always_comb begin
        w_g_op  = 3'b000;
        w_g_a   = WIDTH'(5);
        w_g_b   = WIDTH'(2);
        w_g_res = WIDTH'(3);
        w_g_n   = 1'b0;
        w_g_z   = 1'b0;
        unique case (r_vi)
            3'd1: begin
                w_g_op = 3'b001; w_g_a = WIDTH'(8);
                w_g_b = WIDTH'(3); w_g_res = WIDTH'(16'h000B);
            end
            3'd2: begin
                w_g_op = 3'b010; w_g_a = WIDTH'(16'hCCCC);
                w_g_b = WIDTH'(4); w_g_res = WIDTH'(16'hCCC0);
                w_g_n = 1'b1;
            end
            3'd3: begin
                w_g_op = 3'b011; w_g_a = WIDTH'(16'hCCCC);
                w_g_b = '0; w_g_res = WIDTH'(16'h3333);
            end
            3'd4: begin
                w_g_op = 3'b101; w_g_a = WIDTH'(10);
                w_g_b = WIDTH'(7); w_g_res = WIDTH'(1);
            end
            3'd5: begin
                w_g_op = 3'b000; w_g_a = WIDTH'(7);
                w_g_b = WIDTH'(7); w_g_res = '0;
                w_g_z = 1'b1;
            end
            3'd6: begin
                w_g_op = 3'b000; w_g_a = WIDTH'(2);
                w_g_b = WIDTH'(5); w_g_res = WIDTH'(16'hFFFD);
                w_g_n = 1'b1;
            end
            default: ;
        endcase
    end

    // Case inequality so that X/Z from the ALU is a mismatch, not a skip.
    assign w_mis = (bus.ALUresult !== w_g_res) ||
                   (bus.flagN !== w_g_n) ||
                   (bus.flagZ !== w_g_z);

    assign w_last     = (r_vi == 3'(NUM_VEC - 1));
    assign w_wait_end = (({1'b0, r_wait} + 3'd1) == 3'(SETTLE));
    assign w_go       = start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_fc_nx    = (w_mis && (r_fc != 3'd7)) ? r_fc + 3'd1 : r_fc;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  w_next = (SETTLE == 0) ? S_CHECK : S_WAIT;
            S_WAIT:  if (w_wait_end) w_next = S_CHECK;
            S_CHECK: w_next = w_last ? S_DONE : S_LOAD;
            S_DONE:  if (start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_fc   <= '0;
            r_fi   <= '0;
            r_vi   <= '0;
            r_wait <= '0;
        end else if (w_go) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_fc   <= '0;
            r_fi   <= '0;
            r_vi   <= '0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    r_op   <= w_g_op;
                    r_a    <= w_g_a;
                    r_b    <= w_g_b;
                    r_wait <= '0;
                end
                S_WAIT: r_wait <= r_wait + 2'd1;
                S_CHECK: begin
                    r_fc <= w_fc_nx;
                    if (w_mis && (r_fc == 3'd0)) r_fi <= r_vi;
                    if (w_last) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        r_pass <= (w_fc_nx == 3'd0);
                    end else begin
                        r_vi <= r_vi + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ALUop  = r_op;
    assign bus.srcA   = r_a;
    assign bus.srcB   = r_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign fail_count = r_fc;
    assign fail_idx   = r_fi;
    assign vec_idx    = r_vi;
endmodule
